rx_coef_bank_ram: RTL and testbench

// - Parametrised multi-bank FIR coefficient store for the rx filter chain.
// - NBANKS banks of DEPTH x DATA_W words. One bank is "active" and is swept by
//   the filter. Any other bank can be reloaded at run time.
// - Adds the following to single-table coefficient RAMs: a streamed loader, a

---
 rtl/rx_coef_bank_ram.sv | 199 +++++++++++++++++++
 tb/tb_rx_coef_bank_ram.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rx_coef_bank_ram.sv
// Multi-bank FIR coefficient store: streamed loader, sweep sequencer and a
// bank switch that only takes effect between sweeps.

module rx_coef_bank #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = 9,
  parameter int INIT_VAL = 0
) (
  input  logic              clk,
  input  logic              rrx_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: DATA_W'(INIT_VAL)};
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  // Output register only moves on a read, so the coefficient holds between sweeps.
  always_ff @(posedge clk or posedge rrx_rst)
    if (rrx_rst)   r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];

  assign o_rdata = r_q;
endmodule

module rx_coef_bank_ram #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NBANKS   = 2,
  parameter int BANK_W   = (NBANKS > 2) ? $clog2(NBANKS) : 1,
  parameter int INIT_VAL = 0
) (
  input  logic              clk,
  input  logic              rrx_rst,
  input  logic              ld_start,
  input  logic [BANK_W-1:0] ld_bank,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  input  logic              sel_req,
  input  logic [BANK_W-1:0] sel_bank,
  output logic [BANK_W-1:0] active_bank,
  input  logic              rd_start,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic              rd_busy
);
  localparam logic [0:0] L_IDLE = 1'b0;
  localparam logic [0:0] L_LOAD = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RUN  = 1'b1;
  localparam logic [BANK_W:0]   NB   = (BANK_W+1)'(NBANKS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  logic [0:0]        r_lstate;
  logic [BANK_W-1:0] r_ld_bank;
  logic [ADDR_W-1:0] r_ld_cnt;
  logic              r_ld_done, r_ld_err;

  logic              r_sel_pend;
  logic [BANK_W-1:0] r_sel_bank, r_active;

  logic [0:0]        r_rstate;
  logic [ADDR_W-1:0] r_raddr, r_rd_addr;
  logic              r_rd_vld, r_rd_last;
  logic [BANK_W-1:0] r_rd_sel;

  logic              w_ld_we, w_ld_ok, w_ld_hit, w_sel_ok, w_sel_apply;
  logic              w_busy, w_start_idle, w_start_b2b, w_issue;
  logic [ADDR_W-1:0] w_raddr;
  logic [NBANKS-1:0][DATA_W-1:0] w_q;

  assign w_ld_we  = ld_valid && (r_lstate == L_LOAD);
  assign w_ld_ok  = ({1'b0, ld_bank} < NB) && (ld_bank != r_active) &&
                    !(r_sel_pend && (r_sel_bank == ld_bank));
  assign w_ld_hit = (r_lstate == L_LOAD) && (r_ld_bank == r_sel_bank);
  assign w_sel_ok = ({1'b0, sel_bank} < NB);

  // Busy spans the issue phase plus the word still in the read register.
  assign w_busy       = (r_rstate == R_RUN) || r_rd_vld;
  assign w_sel_apply  = r_sel_pend && !w_busy && !rd_start && !w_ld_hit;
  assign w_start_idle = rd_start && !w_busy;
  // A start during rd_last issues tap 0 at once so the next sweep is gapless.
  assign w_start_b2b  = rd_start && r_rd_vld && r_rd_last;
  assign w_issue      = (r_rstate == R_RUN) || w_start_b2b;
  assign w_raddr      = w_start_b2b ? '0 : r_raddr;

  always_ff @(posedge clk or posedge rrx_rst)
    if (rrx_rst) begin
      r_lstate  <= L_IDLE;
      r_ld_bank <= '0;
      r_ld_cnt  <= '0;
      r_ld_done <= 1'b0;
      r_ld_err  <= 1'b0;
    end else begin
      r_ld_done <= 1'b0;
      r_ld_err  <= 1'b0;
      case (r_lstate)
        L_IDLE:
          if (ld_start) begin
            if (w_ld_ok) begin
              r_lstate  <= L_LOAD;
              r_ld_bank <= ld_bank;
              r_ld_cnt  <= '0;
            end else begin
              r_ld_err  <= 1'b1;
            end
          end
        default:
          if (w_ld_we) begin
            r_ld_cnt <= r_ld_cnt + ADDR_W'(1);
            if (r_ld_cnt == LAST) begin
              r_lstate  <= L_IDLE;
              r_ld_done <= 1'b1;
            end
          end
      endcase
    end

  // A new request overwrites a pending one, even in the cycle the old one lands.
  always_ff @(posedge clk or posedge rrx_rst)
    if (rrx_rst) begin
      r_sel_pend <= 1'b0;
      r_sel_bank <= '0;
      r_active   <= '0;
    end else begin
      if (sel_req && w_sel_ok) begin
        r_sel_pend <= 1'b1;
        r_sel_bank <= sel_bank;
      end else if (w_sel_apply) begin
        r_sel_pend <= 1'b0;
      end
      if (w_sel_apply) r_active <= r_sel_bank;
    end

  always_ff @(posedge clk or posedge rrx_rst)
    if (rrx_rst) begin
      r_rstate  <= R_IDLE;
      r_raddr   <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
      r_rd_addr <= '0;
      r_rd_sel  <= '0;
    end else begin
      r_rd_vld  <= w_issue;
      r_rd_last <= w_issue && (w_raddr == LAST);
      if (w_issue) begin
        r_rd_addr <= w_raddr;
        r_rd_sel  <= r_active;
      end
      if (w_start_idle) begin
        r_rstate <= R_RUN;
        r_raddr  <= '0;
      end else if (w_issue) begin
        r_rstate <= (w_raddr == LAST) ? R_IDLE : R_RUN;
        r_raddr  <= w_raddr + ADDR_W'(1);
      end
    end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    rx_coef_bank #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .INIT_VAL(INIT_VAL)
    ) u_bank (
      .clk    (clk),
      .rrx_rst(rrx_rst),
      .i_we   (w_ld_we && (r_ld_bank == BANK_W'(b))),
      .i_waddr(r_ld_cnt),
      .i_wdata(ld_data),
      .i_re   (w_issue && (r_active == BANK_W'(b))),
      .i_raddr(w_raddr),
      .o_rdata(w_q[b])
    );
  end

  assign ld_ready    = (r_lstate == L_LOAD);
  assign ld_done     = r_ld_done;
  assign ld_err      = r_ld_err;
  assign active_bank = r_active;
  assign rd_valid    = r_rd_vld;
  assign rd_data     = w_q[r_rd_sel];
  assign rd_addr     = r_rd_addr;
  assign rd_last     = r_rd_last;
  assign rd_busy     = w_busy;
endmodule

// File: tb/tb_rx_coef_bank_ram.sv
// Directed bench for rx_coef_bank_ram: load, switch, sweep, back-to-back and
// reset-during-load scenarios with hand-computed expectations.

module tb_rx_coef_bank_ram;
  localparam int DW = 16, DEPTH = 512, AW = 9, NB = 2, BW = 1;

  logic          clk = 1'b0, rrx_rst = 1'b1;
  logic          ld_start = 1'b0, ld_valid = 1'b0, sel_req = 1'b0, rd_start = 1'b0;
  logic [BW-1:0] ld_bank = '0, sel_bank = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready, ld_done, ld_err, rd_valid, rd_last, rd_busy;
  logic [BW-1:0] active_bank;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  int            n_chk = 0, n_pass = 0;

  rx_coef_bank_ram #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NBANKS(NB), .BANK_W(BW), .INIT_VAL(0)
  ) dut (
    .clk(clk), .rrx_rst(rrx_rst),
    .ld_start(ld_start), .ld_bank(ld_bank), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err),
    .sel_req(sel_req), .sel_bank(sel_bank), .active_bank(active_bank),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_addr(rd_addr), .rd_last(rd_last), .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Streams DEPTH words base+n; gap toggles ld_valid 1010..; abort_at returns early.
  task automatic load(input logic [BW-1:0] b, input logic [DW-1:0] base,
                      input bit gap, input int abort_at);
    int n = 0;
    int k = 0;
    cyc(); ld_start = 1'b1; ld_bank = b; ld_valid = 1'b0;
    while (n < DEPTH && k < 3*DEPTH) begin
      cyc();
      ld_start = 1'b0;
      ld_valid = (gap && k[0]) ? 1'b0 : 1'b1;
      ld_data  = base + DW'(n);
      @(negedge clk);
      if (k == 0) chk("ld_rdy_up", {ld_ready, ld_err}, 2'b10);
      if (ld_valid && ld_ready) n++;
      k++;
      if (n == abort_at) return;
    end
    chk("ld_words", n, DEPTH);
    cyc(); ld_valid = 1'b0; @(negedge clk);
    chk("ld_done", {ld_done, ld_ready}, 2'b10);
    cyc(); @(negedge clk);
    chk("ld_done_clr", ld_done, 0);
  endtask

  // One full sweep; optional sel_req / ld_start injected at given word indices.
  task automatic sweep(input logic [BW-1:0] act, input logic [DW-1:0] base,
                       input bit first, input bit chain,
                       input int sel_at, input logic [BW-1:0] sb,
                       input int ld_at, input logic [BW-1:0] lb);
    if (first) begin
      cyc(); rd_start = 1'b1;
      cyc(); rd_start = 1'b0; @(negedge clk);
      chk("rd_lat", {rd_busy, rd_valid}, 2'b10);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      rd_start = chain && (i == DEPTH-1);
      sel_req  = (i == sel_at); sel_bank = sb;
      ld_start = (i == ld_at);  ld_bank  = lb;
      @(negedge clk);
      chk("sweep", {rd_busy, rd_valid, rd_last, active_bank, rd_addr, rd_data},
          {1'b1, 1'b1, (i == DEPTH-1), act, AW'(i), base + DW'(i)});
      if (ld_at >= 0 && i == ld_at + 1) chk("ld_err_pend", {ld_err, ld_ready}, 2'b10);
    end
  endtask

  task automatic post(input logic [DW-1:0] hold, input logic [BW-1:0] act);
    cyc(); rd_start = 1'b0; sel_req = 1'b0; ld_start = 1'b0; @(negedge clk);
    chk("sweep_end", {rd_busy, rd_valid, rd_last, rd_data}, {3'b000, hold});
    chk("act_hold", active_bank, act);
  endtask

  task automatic select(input logic [BW-1:0] b);
    cyc(); sel_req = 1'b1; sel_bank = b;
    cyc(); sel_req = 1'b0;
    cyc(); @(negedge clk);
    chk("act_sw", active_bank, b);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ld", {ld_ready, ld_done, ld_err}, 0);
    chk("rst_rd", {rd_busy, rd_valid, rd_last, rd_addr, rd_data}, 0);
    chk("rst_act", active_bank, 0);
    cyc(); rrx_rst = 1'b0;

    // loading the active bank is rejected and nothing is accepted
    cyc(); ld_start = 1'b1; ld_bank = 1'b0;
    cyc(); ld_start = 1'b0; ld_valid = 1'b1; @(negedge clk);
    chk("ld_err", {ld_err, ld_ready}, 2'b10);
    cyc(); @(negedge clk);
    chk("ld_err_clr", {ld_err, ld_ready}, 2'b00);
    ld_valid = 1'b0;

    load(1'b1, 16'h0000, 1'b0, -1);
    select(1'b1);
    sweep(1'b1, 16'h0000, 1'b1, 1'b0, -1, 1'b0, -1, 1'b0);
    post(16'd511, 1'b1);

    load(1'b0, 16'hA000, 1'b1, -1);
    // switch requested mid-sweep waits; pending target cannot be loaded
    sweep(1'b1, 16'h0000, 1'b1, 1'b0, 100, 1'b0, 300, 1'b0);
    post(16'd511, 1'b1);
    cyc(); @(negedge clk);
    chk("act_after", active_bank, 0);

    sweep(1'b0, 16'hA000, 1'b1, 1'b1, -1, 1'b0, -1, 1'b0);
    sweep(1'b0, 16'hA000, 1'b0, 1'b0, -1, 1'b0, -1, 1'b0);
    post(16'hA1FF, 1'b0);

    // reset during a load, with a switch to the loading bank pending
    load(1'b1, 16'h5000, 1'b0, 200);
    cyc(); sel_req = 1'b1; sel_bank = 1'b1;
    cyc(); sel_req = 1'b0;
    cyc(); rrx_rst = 1'b1; ld_valid = 1'b0; #1;
    chk("rst_mid", {ld_ready, ld_done, ld_err, rd_busy, rd_valid, active_bank}, 0);
    cyc(); cyc(); rrx_rst = 1'b0;
    load(1'b1, 16'h5000, 1'b0, -1);
    cyc(); cyc(); @(negedge clk);
    chk("pend_clr", active_bank, 0);
    select(1'b1);
    sweep(1'b1, 16'h5000, 1'b1, 1'b0, -1, 1'b0, -1, 1'b0);
    post(16'h51FF, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
